// File: rtl/i2s_tx_pkg.sv
// i2s_tx_pkg: shared audio timing constants for the I2S transmitter.
//   FRAME_CYCLES     - clk cycles per stereo frame (sets the sample rate)
//   BCK_DIV          - clk cycles per bit clock period
//   SLOTS_PER_CH     - bit clocks per channel half-frame
//   AUDIO_DATA_WIDTH - default sample word width
// Derived widths split the frame counter into {lrck, slot, bck phase}.
package i2s_tx_pkg;

  localparam int FRAME_CYCLES     = 512;
  localparam int BCK_DIV          = 8;
  localparam int SLOTS_PER_CH     = 32;
  localparam int AUDIO_DATA_WIDTH = 24;

  localparam int CNT_WIDTH  = $clog2(FRAME_CYCLES);   // 9
  localparam int BCK_BITS   = $clog2(BCK_DIV);        // 3
  localparam int SLOT_WIDTH = $clog2(SLOTS_PER_CH);   // 5

endpackage

// File: rtl/i2s_tx.sv
// i2s_tx: serialises a 24-bit stereo sample pair onto a Philips-aligned I2S
// bus and acts as the audio timebase for the upstream generators.
//
// Ports:
//   clk          system clock (25 MHz)
//   rst          synchronous, active-high reset
//   left_data    left sample, two's complement, captured once per frame
//   right_data   right sample, two's complement, captured once per frame
//   next_sample  one-cycle strobe in the first cycle of every frame
//   i2s_lrck     word select, 0 = left, 1 = right
//   i2s_bck      bit clock, clk/8, low phase first
//   i2s_data     serial data, MSB one bit clock after the LRCK edge
//
// The frame counter cnt splits as {lrck, slot[4:0], bck phase[2:0]}. Every
// output is a flop loaded from the value cnt is about to take, so during the
// cycle where cnt == c the outputs already show the function of c.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_DATA_WIDTH  // must be <= 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] left_data,
  input  logic [DATA_WIDTH-1:0] right_data,
  output logic                  next_sample,
  output logic                  i2s_lrck,
  output logic                  i2s_bck,
  output logic                  i2s_data
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAME_CYCLES - 1);

  logic [CNT_WIDTH-1:0]    cnt_reg;
  logic [CNT_WIDTH-1:0]    cnt_next;
  logic                    running_reg;
  logic [DATA_WIDTH-1:0]   hold_l_reg;
  logic [DATA_WIDTH-1:0]   hold_r_reg;
  logic [DATA_WIDTH-1:0]   word;
  logic [SLOT_WIDTH-1:0]   slot_next;
  logic [SLOTS_PER_CH-1:0] slot_bits;

  logic next_sample_reg;
  logic lrck_reg;
  logic bck_reg;
  logic data_reg;

  // cnt sits at 0 through reset and is held at 0 for the first edge after
  // release, so the first post-reset cycle is frame cycle 0 with the
  // next_sample pulse registered on the same edge.
  always_comb begin
    cnt_next = '0;
    if (running_reg) begin
      cnt_next = cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign slot_next = cnt_next[BCK_BITS +: SLOT_WIDTH];
  assign word      = cnt_next[CNT_WIDTH-1] ? hold_r_reg : hold_l_reg;

  // Bit presented in each slot of the channel: slot 0 is the one-bit
  // Philips delay, slots 1..DATA_WIDTH carry MSB..LSB, the rest pad with 0.
  for (genvar gi = 0; gi < SLOTS_PER_CH; gi++) begin : g_slot
    if (gi >= 1 && gi <= DATA_WIDTH) begin : g_bit
      assign slot_bits[gi] = word[DATA_WIDTH - gi];
    end else begin : g_pad
      assign slot_bits[gi] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg         <= '0;
      running_reg     <= 1'b0;
      hold_l_reg      <= '0;
      hold_r_reg      <= '0;
      next_sample_reg <= 1'b0;
      lrck_reg        <= 1'b0;
      bck_reg         <= 1'b0;
      data_reg        <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      running_reg <= 1'b1;
      // Both channels latch on the same edge so the pair stays coherent.
      // The new words are first used at slot 1 of the next frame.
      if (cnt_reg == LAST_CNT) begin
        hold_l_reg <= left_data;
        hold_r_reg <= right_data;
      end
      next_sample_reg <= (cnt_next == '0);
      lrck_reg        <= cnt_next[CNT_WIDTH-1];
      bck_reg         <= cnt_next[BCK_BITS-1];
      data_reg        <= slot_bits[slot_next];
    end
  end

  assign next_sample = next_sample_reg;
  assign i2s_lrck    = lrck_reg;
  assign i2s_bck     = bck_reg;
  assign i2s_data    = data_reg;

endmodule
